mux_out_edge_capture: RTL and testbench

- Downstream stage of the 2:1 mux under test. Consumes the mux output `y`, which is asynchronous to `clk` and may glitch.
- Synchronizes `y` into the `clk` domain, detects rising and falling edges, and timestamps each edge.
- Queues edge events in a small FIFO with a valid/ready read port, so simulation and synthesis netlists can be compared edge-for-edge.
- Also keeps a saturating toggle count and a sticky overflow flag.

---
 rtl/mux_cap_pkg.sv | 19 +
 rtl/mux_out_edge_capture_if.sv | 18 +
 rtl/edge_evt_fifo.sv | 89 ++++++++
 rtl/mux_out_edge_capture.sv | 110 +++++++++++
 tb/tb_mux_out_edge_capture.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_cap_pkg.sv
// Shared definitions for the mux output edge-capture block.
// Holds the event-word layout helpers and the polarity encodings used by the
// capture top and by anything that decodes evt_data.
package mux_cap_pkg;

  localparam logic EVT_RISE = 1'b1;
  localparam logic EVT_FALL = 1'b0;

  // Width of one event word: timestamp plus one polarity bit.
  function automatic int evt_width(input int ts_width);
    return ts_width + 1;
  endfunction

  // Index of the polarity bit inside an event word (the MSB).
  function automatic int evt_pol_bit(input int ts_width);
    return ts_width;
  endfunction

endpackage

// File: rtl/mux_out_edge_capture_if.sv
// Valid/ready event read port of the edge-capture block.
// Ports (signals):
//   valid - head event present on data
//   ready - consumer accepts the head event when valid && ready
//   data  - [TS_WIDTH] polarity (1 = rise), [TS_WIDTH-1:0] timestamp
// master = event producer (capture block), slave = event consumer.
interface mux_out_edge_capture_if #(
  parameter int TS_WIDTH = 16
);

  logic                valid;
  logic                ready;
  logic [TS_WIDTH:0]   data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/edge_evt_fifo.sv
// Small synchronous event FIFO with a registered head-data output.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   srst       - synchronous clear (empties the FIFO, head data is kept)
//   push, din  - write request and data; accepted if not full or popping
//   pop        - read request; ignored while empty
//   dout       - head entry; holds its last value while empty
//   valid      - FIFO non-empty
//   full       - FIFO holds DEPTH entries
//   level      - occupancy 0..DEPTH
module edge_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       srst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    rd_ptr_next_s;
  logic [LW-1:0]    level_next_s;
  logic             push_en_s;
  logic             pop_en_s;
  logic [WIDTH-1:0] head_next_s;

  // Accept/retire decisions, next read pointer, next level and next head word.
  always_comb begin
    pop_en_s      = pop & (level != LW'(0));
    // A full FIFO still takes a write when the head is retired in the same cycle.
    push_en_s     = push & ((level != LW'(DEPTH)) | pop_en_s);
    full          = (level == LW'(DEPTH));
    rd_ptr_next_s = pop_en_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
    case ({push_en_s, pop_en_s})
      2'b10:   level_next_s = level + LW'(1);
      2'b01:   level_next_s = level - LW'(1);
      default: level_next_s = level;
    endcase
    // Bypass the incoming word when it lands directly in the new head slot.
    if (push_en_s && (wr_ptr_r == rd_ptr_next_s)) begin
      head_next_s = din;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // Storage, pointers, level and registered head/valid outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= WIDTH'(0);
      end
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level    <= LW'(0);
      valid    <= 1'b0;
      dout     <= WIDTH'(0);
    end else if (srst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level    <= LW'(0);
      valid    <= 1'b0;
    end else begin
      if (push_en_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r <= rd_ptr_next_s;
      level    <= level_next_s;
      valid    <= (level_next_s != LW'(0));
      if (level_next_s != LW'(0)) begin
        dout <= head_next_s;
      end
    end
  end

endmodule

// File: rtl/mux_out_edge_capture.sv
// Edge capture for the asynchronous (possibly glitchy) 2:1 mux output.
// Synchronizes y_in, detects rising/falling edges, timestamps each edge with a
// free-running counter and queues {polarity, timestamp} events in a FIFO.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   y_in        - mux output, asynchronous to clk
//   clear       - synchronous clear of FIFO, timestamp, toggle count, overflow
//   evt         - valid/ready event read port (master side)
//   toggle_cnt  - saturating count of detected edges
//   overflow    - sticky: an edge was dropped because the FIFO was full
//   fifo_level  - FIFO occupancy 0..DEPTH
module mux_out_edge_capture
  import mux_cap_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TS_WIDTH    = 16,
  parameter int DEPTH       = 4,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       y_in,
  input  logic                       clear,
  mux_out_edge_capture_if.master     evt,
  output logic [CNT_WIDTH-1:0]       toggle_cnt,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int EW          = evt_width(TS_WIDTH);
  localparam int EVT_POL_BIT = evt_pol_bit(TS_WIDTH);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   y_sync_s;
  logic                   y_prev_r;
  logic                   edge_s;
  logic                   push_s;
  logic                   full_s;
  logic [TS_WIDTH-1:0]    ts_r;
  logic [EW-1:0]          evt_word_s;
  logic [EW-1:0]          head_s;
  logic                   valid_s;

  // Edge detection on the synchronized sample and event word assembly.
  always_comb begin
    y_sync_s                      = sync_r[SYNC_STAGES-1];
    edge_s                        = y_sync_s ^ y_prev_r;
    evt_word_s                    = EW'(0);
    evt_word_s[TS_WIDTH-1:0]      = ts_r;
    evt_word_s[EVT_POL_BIT]       = y_sync_s ? EVT_RISE : EVT_FALL;
    // An edge seen in a clear cycle is discarded.
    push_s                        = edge_s & ~clear;
  end

  // Synchronizer chain and previous sample; deliberately untouched by clear so
  // that no spurious edge appears after a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r   <= {SYNC_STAGES{1'b0}};
      y_prev_r <= 1'b0;
    end else begin
      sync_r   <= {sync_r[SYNC_STAGES-2:0], y_in};
      y_prev_r <= y_sync_s;
    end
  end

  // Timestamp counter, saturating toggle counter and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_r       <= TS_WIDTH'(0);
      toggle_cnt <= CNT_WIDTH'(0);
      overflow   <= 1'b0;
    end else if (clear) begin
      ts_r       <= TS_WIDTH'(0);
      toggle_cnt <= CNT_WIDTH'(0);
      overflow   <= 1'b0;
    end else begin
      ts_r <= ts_r + TS_WIDTH'(1);
      if (edge_s) begin
        if (toggle_cnt != {CNT_WIDTH{1'b1}}) begin
          toggle_cnt <= toggle_cnt + CNT_WIDTH'(1);
        end
        // Full implies non-empty, so ready alone tells whether a pop frees a slot.
        if (full_s && !evt.ready) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  edge_evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .srst  (clear),
    .push  (push_s),
    .din   (evt_word_s),
    .pop   (evt.ready),
    .dout  (head_s),
    .valid (valid_s),
    .full  (full_s),
    .level (fifo_level)
  );

  assign evt.valid = valid_s;
  assign evt.data  = head_s;

endmodule

// File: tb/tb_mux_out_edge_capture.sv
// Self-checking bench for mux_out_edge_capture: directed scenarios plus
// randomized stimulus compared every cycle against an event-queue model.
module tb_mux_out_edge_capture;
  import mux_cap_pkg::*;

  localparam int SYNC  = 2;
  localparam int TSW   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          y_in  = 1'b0;
  logic          clear = 1'b0;
  logic [CW-1:0] toggle_cnt;
  logic          overflow;
  logic [LW-1:0] fifo_level;

  mux_out_edge_capture_if #(.TS_WIDTH(TSW)) evt_bus ();

  mux_out_edge_capture #(
    .SYNC_STAGES (SYNC),
    .TS_WIDTH    (TSW),
    .DEPTH       (DEPTH),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .y_in       (y_in),
    .clear      (clear),
    .evt        (evt_bus),
    .toggle_cnt (toggle_cnt),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  // Reference model: history of sampled y_in, queue of pending events.
  bit           hist[$];
  bit [TSW:0]   mq[$];
  int           m_cnt;
  bit           m_ovf;
  int           m_ts;
  bit [TSW:0]   m_last;
  int           errors = 0;
  int           checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // y_in sampled at clock edge i (1-based since reset release); 0 before that.
  function automatic bit hval(input int i);
    return (i < 1) ? 1'b0 : hist[i-1];
  endfunction

  // True when the synchronized signal differs from its previous sample in the
  // cycle before the next clock edge, i.e. an edge is detected in that cycle.
  function automatic bit edge_pending();
    int e;
    e = hist.size() + 1;
    return hval(e - SYNC) != hval(e - SYNC - 1);
  endfunction

  task automatic model_reset();
    hist.delete();
    mq.delete();
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_ts   = 0;
    m_last = '0;
  endtask

  task automatic check_all();
    check_eq("valid", evt_bus.valid, (mq.size() > 0));
    check_eq("data",  evt_bus.data,  m_last);
    check_eq("level", fifo_level,    mq.size());
    check_eq("cnt",   toggle_cnt,    m_cnt);
    check_eq("ovf",   overflow,      m_ovf);
  endtask

  // Advance one clock with the current inputs, update the model, then check.
  task automatic step();
    int e;
    bit ys;
    bit yp;
    bit pop;
    e   = hist.size() + 1;
    ys  = hval(e - SYNC);
    yp  = hval(e - SYNC - 1);
    pop = evt_bus.ready && (mq.size() > 0);
    if (clear) begin
      mq.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
      m_ts  = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (ys != yp) begin
        if (mq.size() < DEPTH) mq.push_back({ys, TSW'(m_ts)});
        else m_ovf = 1'b1;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end
      m_ts = (m_ts + 1) % (1 << TSW);
    end
    hist.push_back(y_in);
    if (mq.size() > 0) m_last = mq[0];
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    bit [TSW:0] exp_word;
    int         prev_ts;
    int         cur_ts;
    bit         found;

    evt_bus.ready = 1'b0;
    model_reset();

    // Reset held while y_in toggles: nothing may be captured.
    repeat (6) begin
      @(negedge clk);
      y_in = ~y_in;
    end
    check_eq("rst_valid", evt_bus.valid, 0);
    check_eq("rst_cnt",   toggle_cnt,    0);
    check_eq("rst_ovf",   overflow,      0);
    check_eq("rst_level", fifo_level,    0);
    y_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) step();

    // Single rise: timestamp 0 after the clear edge, y_in set up before edge 5.
    do_clear();
    repeat (4) step();
    y_in = 1'b1;
    step();
    step();
    check_eq("rise_lat_early", evt_bus.valid, 0);
    step();
    exp_word = {EVT_RISE, TSW'(6)};
    check_eq("rise_valid", evt_bus.valid, 1);
    check_eq("rise_data",  evt_bus.data,  exp_word);
    check_eq("rise_cnt",   toggle_cnt,    1);
    evt_bus.ready = 1'b1;
    step();
    evt_bus.ready = 1'b0;
    check_eq("rise_popped", evt_bus.valid, 0);

    // Burst of 6 edges into a 4-deep FIFO without draining.
    y_in = 1'b0;
    repeat (4) step();
    do_clear();
    for (int i = 0; i < 6; i++) begin
      y_in = ~y_in;
      repeat (3) step();
    end
    check_eq("burst_level", fifo_level, DEPTH);
    check_eq("burst_cnt",   toggle_cnt, 6);
    check_eq("burst_ovf",   overflow,   1);
    evt_bus.ready = 1'b1;
    prev_ts = 0;
    for (int k = 0; k < DEPTH; k++) begin
      cur_ts = int'(evt_bus.data[TSW-1:0]);
      check_eq("drain_pol", evt_bus.data[TSW], (k % 2 == 0) ? EVT_RISE : EVT_FALL);
      if (k > 0) check_eq("drain_spacing", (cur_ts - prev_ts) & ((1 << TSW) - 1), 3);
      prev_ts = cur_ts;
      step();
    end
    evt_bus.ready = 1'b0;
    check_eq("drain_empty", evt_bus.valid, 0);

    // Push and pop in the same cycle while full.
    do_clear();
    for (int i = 0; i < DEPTH; i++) begin
      y_in = ~y_in;
      repeat (3) step();
    end
    check_eq("simul_full", fifo_level, DEPTH);
    y_in  = ~y_in;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (edge_pending()) begin
        evt_bus.ready = 1'b1;
        found = 1'b1;
      end
      step();
      evt_bus.ready = 1'b0;
    end
    check_eq("simul_found", found,      1);
    check_eq("simul_level", fifo_level, DEPTH);
    check_eq("simul_ovf",   overflow,   0);

    // Timestamp wrap: edge detected at count 19 carries timestamp 3.
    do_clear();
    repeat (17) step();
    y_in = ~y_in;
    repeat (3) step();
    check_eq("wrap_valid", evt_bus.valid, 1);
    check_eq("wrap_ts",    evt_bus.data[TSW-1:0], 3);

    // Clear coincident with a detected edge discards that edge.
    y_in  = ~y_in;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (edge_pending()) begin
        clear = 1'b1;
        found = 1'b1;
      end
      step();
      clear = 1'b0;
    end
    check_eq("clr_found", found,         1);
    check_eq("clr_level", fifo_level,    0);
    check_eq("clr_cnt",   toggle_cnt,    0);
    check_eq("clr_valid", evt_bus.valid, 0);
    step();
    check_eq("clr_nospur", evt_bus.valid, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) y_in = ~y_in;
      evt_bus.ready = 1'($urandom_range(0, 1));
      clear = ($urandom_range(0, 49) == 0);
      step();
    end
    clear         = 1'b0;
    evt_bus.ready = 1'b0;

    // Asynchronous reset with three queued events.
    do_clear();
    for (int i = 0; i < 3; i++) begin
      y_in = ~y_in;
      repeat (3) step();
    end
    check_eq("arst_pre_level", fifo_level, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_level", fifo_level,    0);
    check_eq("arst_valid", evt_bus.valid, 0);
    check_eq("arst_data",  evt_bus.data,  0);
    check_eq("arst_cnt",   toggle_cnt,    0);
    model_reset();
    y_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
